// File: rtl/act_row_sched_pkg.sv
// act_row_sched_pkg: phase/state codes shared by the row scheduler and its bench
package act_row_sched_pkg;
  localparam int PHASE_W = 3;
  typedef enum logic [PHASE_W-1:0] {S_IDLE, S_PREP, S_LOAD, S_STREAM, S_DONE} state_t;
endpackage

// File: rtl/act_row_sched_pulse_gen.sv
// act_row_sched_pulse_gen: registered single-cycle pulse that defers a request seen during stall
module act_row_sched_pulse_gen (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic stall,
  input  logic req,
  output logic pulse
);
  logic pend;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pulse <= 1'b0;
      pend  <= 1'b0;
    end else begin
      pulse <= !clr && !stall && (req || pend);
      pend  <= !clr && stall && (req || pend);
    end
endmodule

// File: rtl/act_row_sched.sv
// act_row_sched: row scheduler sequencing flag-RAM and column reads for the activation buffer
module act_row_sched
  import act_row_sched_pkg::*;
#(
  parameter int ROW_W      = 5,
  parameter int VAL_W      = 5,
  parameter int FLAG_LAT   = 2,
  parameter int M1_ROW_CYC = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_mode,
  input  logic [ROW_W-1:0]   cfg_row_num,
  input  logic               abort,
  input  logic               stall,
  input  logic [VAL_W-1:0]   row_val_num_act_real,
  output logic               mode,
  output logic               start,
  output logic               en,
  output logic               row_cal_done,
  output logic               row_index_count_3,
  output logic               zero_flag,
  output logic [PHASE_W-1:0] phase,
  output logic [ROW_W-1:0]   row_idx,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2((FLAG_LAT > M1_ROW_CYC ? FLAG_LAT : M1_ROW_CYC) + 1);
  state_t st, nst;
  logic [ROW_W-1:0] row_num;
  logic [VAL_W-1:0] elem_cnt;
  logic [CW-1:0] wcnt, cyc_cnt;
  logic [1:0] r3;
  logic adv, last, row_end, start_req, en_req, rcd_req, ric_req;
  assign adv = !stall;
  assign last = row_idx == row_num - ROW_W'(1);
  assign start_req = st == S_PREP;
  assign phase = st;
  always_comb begin
    nst = st;
    row_end = 1'b0;
    rcd_req = 1'b0;
    en_req = 1'b0;
    ric_req = 1'b0;
    unique case (st)
      S_IDLE:  nst = cfg_start ? (cfg_row_num == '0 ? S_DONE : S_PREP) : S_IDLE;
      S_PREP:  nst = adv ? S_LOAD : S_PREP;
      S_LOAD:  nst = (adv && wcnt == CW'(FLAG_LAT - 1)) ? S_STREAM : S_LOAD;
      S_STREAM: begin
        // zero-valid rows finish one cycle after zero_flag rises
        row_end = mode ? cyc_cnt == CW'(M1_ROW_CYC - 1)
                : (row_val_num_act_real == '0 ? zero_flag
                   : elem_cnt == row_val_num_act_real - VAL_W'(1));
        rcd_req = row_end;
        en_req = row_end && !mode && !last;
        ric_req = row_end && mode && r3 == 2'd2;
        nst = (row_end && adv) ? (last ? S_DONE : (mode ? S_STREAM : S_LOAD)) : S_STREAM;
      end
      S_DONE:  nst = S_IDLE;
      default: nst = S_IDLE;
    endcase
    if (abort) nst = S_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mode <= 1'b0;
      row_num <= '0;
      row_idx <= '0;
      wcnt <= '0;
      cyc_cnt <= '0;
      elem_cnt <= '0;
      r3 <= '0;
      zero_flag <= 1'b0;
    end else begin
      st <= nst;
      busy <= nst != S_IDLE;
      done <= st == S_DONE && !abort;
      if (abort) begin
        wcnt <= '0;
        cyc_cnt <= '0;
        elem_cnt <= '0;
        zero_flag <= 1'b0;
      end else if (st == S_IDLE) begin
        if (cfg_start) begin
          mode <= cfg_mode;
          row_num <= cfg_row_num;
          row_idx <= '0;
          r3 <= '0;
        end
      end else if (adv) begin
        wcnt <= (st == S_LOAD && wcnt != CW'(FLAG_LAT - 1)) ? wcnt + 1'b1 : '0;
        if (st == S_STREAM) begin
          if (mode) cyc_cnt <= row_end ? '0 : cyc_cnt + 1'b1;
          else if (row_val_num_act_real == '0) zero_flag <= !zero_flag;
          else elem_cnt <= row_end ? '0 : elem_cnt + 1'b1;
          if (row_end) begin
            row_idx <= row_idx + 1'b1;
            if (mode) r3 <= r3 == 2'd2 ? 2'd0 : r3 + 2'd1;
          end
        end
      end
    end
  act_row_sched_pulse_gen u_start (.clk(clk), .reset(reset), .clr(abort), .stall(stall), .req(start_req), .pulse(start));
  act_row_sched_pulse_gen u_en    (.clk(clk), .reset(reset), .clr(abort), .stall(stall), .req(en_req),    .pulse(en));
  act_row_sched_pulse_gen u_rcd   (.clk(clk), .reset(reset), .clr(abort), .stall(stall), .req(rcd_req),   .pulse(row_cal_done));
  act_row_sched_pulse_gen u_ric   (.clk(clk), .reset(reset), .clr(abort), .stall(stall), .req(ric_req),   .pulse(row_index_count_3));
endmodule

// File: tb/tb_act_row_sched.sv
// tb_act_row_sched: directed cycle-exact checks of the row scheduler
module tb_act_row_sched;
  import act_row_sched_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_mode = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  logic [4:0] cfg_row_num = '0;
  logic [4:0] row_val = '0;
  logic mode, start, en, row_cal_done, row_index_count_3, zero_flag, busy, done;
  logic [PHASE_W-1:0] phase;
  logic [4:0] row_idx;
  int passed = 0;
  int total = 0;
  int n_start = 0;
  int n_en = 0;
  int n_rcd = 0;
  int n_ric = 0;
  always #5 clk = ~clk;
  act_row_sched dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_row_num(cfg_row_num), .abort(abort), .stall(stall),
    .row_val_num_act_real(row_val), .mode(mode), .start(start), .en(en),
    .row_cal_done(row_cal_done), .row_index_count_3(row_index_count_3),
    .zero_flag(zero_flag), .phase(phase), .row_idx(row_idx), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_start += int'(start);
      n_en += int'(en);
      n_rcd += int'(row_cal_done);
      n_ric += int'(row_index_count_3);
    end
  endtask
  task automatic launch(input logic m, input logic [4:0] rows);
    cfg_mode = m;
    cfg_row_num = rows;
    cfg_start = 1'b1;
    n_start = 0;
    n_en = 0;
    n_rcd = 0;
    n_ric = 0;
    tick();
    cfg_start = 1'b0;
  endtask
  initial begin
    tick(2);
    check("rst_phase", phase, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_mode", mode, 0);
    reset = 1'b1;
    tick();
    // T1: serial, two rows of 3 and 1 valid activations
    row_val = 5'd3;
    launch(1'b0, 5'd2);
    check("t1_prep", phase, S_PREP);
    check("t1_busy", busy, 1);
    check("t1_no_start_yet", start, 0);
    tick();
    check("t1_start", start, 1);
    check("t1_load", phase, S_LOAD);
    tick(4);
    check("t1_r0_stream", phase, S_STREAM);
    check("t1_r0_no_rcd", row_cal_done, 0);
    tick();
    check("t1_r0_rcd", row_cal_done, 1);
    check("t1_r0_en", en, 1);
    check("t1_r0_idx", row_idx, 1);
    row_val = 5'd1;
    tick(3);
    check("t1_r1_rcd", row_cal_done, 1);
    check("t1_r1_no_en", en, 0);
    check("t1_r1_idx", row_idx, 2);
    check("t1_done_state", phase, S_DONE);
    tick();
    check("t1_done", done, 1);
    check("t1_idle_busy", busy, 0);
    tick();
    check("t1_done_1cyc", done, 0);
    check("t1_n_en", n_en, 1);
    check("t1_n_start", n_start, 1);
    check("t1_n_rcd", n_rcd, 2);
    // T2: row with zero valid activations
    row_val = 5'd0;
    launch(1'b0, 5'd1);
    tick(3);
    check("t2_zf_low", zero_flag, 0);
    tick();
    check("t2_zf_high", zero_flag, 1);
    check("t2_no_rcd", row_cal_done, 0);
    tick();
    check("t2_zf_clear", zero_flag, 0);
    check("t2_rcd", row_cal_done, 1);
    check("t2_done_state", phase, S_DONE);
    tick();
    check("t2_done", done, 1);
    check("t2_n_rcd", n_rcd, 1);
    // T3: parallel mode, six rows, cfg_start while busy must be ignored
    launch(1'b1, 5'd6);
    for (int k = 2; k <= 23; k++) begin
      tick();
      cfg_start = (k == 7);
      cfg_row_num = 5'd3;
      if (k == 10) begin
        check("t3_r1_rcd", row_cal_done, 1);
        check("t3_r1_no_ric", row_index_count_3, 0);
      end
      if (k == 13) begin
        check("t3_r2_rcd", row_cal_done, 1);
        check("t3_r2_ric", row_index_count_3, 1);
        check("t3_r2_idx", row_idx, 3);
        check("t3_r2_stream", phase, S_STREAM);
      end
      if (k == 22) begin
        check("t3_r5_ric", row_index_count_3, 1);
        check("t3_r5_done_state", phase, S_DONE);
      end
      if (k == 23) check("t3_done", done, 1);
    end
    cfg_start = 1'b0;
    check("t3_mode", mode, 1);
    check("t3_n_rcd", n_rcd, 6);
    check("t3_n_ric", n_ric, 2);
    check("t3_n_en", n_en, 0);
    check("t3_n_start", n_start, 1);
    // T4: stall four cycles on the last element of the row
    row_val = 5'd3;
    launch(1'b0, 5'd1);
    tick(5);
    stall = 1'b1;
    tick(4);
    check("t4_stalled_rcd", row_cal_done, 0);
    check("t4_stalled_idx", row_idx, 0);
    check("t4_stalled_phase", phase, S_STREAM);
    check("t4_stalled_n_rcd", n_rcd, 0);
    stall = 1'b0;
    tick();
    check("t4_rcd", row_cal_done, 1);
    check("t4_idx", row_idx, 1);
    tick();
    check("t4_done", done, 1);
    check("t4_n_rcd", n_rcd, 1);
    // T5: abort in row 3, then a clean relaunch
    row_val = 5'd1;
    launch(1'b0, 5'd5);
    tick(12);
    check("t5_pre_idx", row_idx, 3);
    check("t5_pre_phase", phase, S_STREAM);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle", phase, S_IDLE);
    check("t5_busy", busy, 0);
    check("t5_no_rcd", row_cal_done, 0);
    check("t5_no_en", en, 0);
    tick();
    check("t5_no_done", done, 0);
    check("t5_n_rcd", n_rcd, 3);
    row_val = 5'd2;
    launch(1'b0, 5'd1);
    check("t5_re_idx", row_idx, 0);
    check("t5_re_prep", phase, S_PREP);
    tick(5);
    check("t5_re_rcd", row_cal_done, 1);
    check("t5_re_idx1", row_idx, 1);
    tick();
    check("t5_re_done", done, 1);
    // T6: empty tile, then async reset while in LOAD
    launch(1'b0, 5'd0);
    check("t6_done_state", phase, S_DONE);
    check("t6_busy", busy, 1);
    check("t6_no_done_yet", done, 0);
    tick();
    check("t6_done", done, 1);
    check("t6_idle", phase, S_IDLE);
    check("t6_n_start", n_start, 0);
    check("t6_n_en", n_en, 0);
    launch(1'b1, 5'd2);
    tick();
    check("t6_load", phase, S_LOAD);
    check("t6_mode_latched", mode, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_phase", phase, S_IDLE);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_start", start, 0);
    check("t6_rst_mode", mode, 0);
    check("t6_rst_idx", row_idx, 0);
    tick();
    reset = 1'b1;
    tick(2);
    check("t6_stay_idle", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
